// File: rtl/alu_pkg.sv
// alu_pkg: function codes, data width and shifter modes shared by the ALU, decoder and board harness.
// Rev 1.0
`default_nettype none

package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_NOR  = 4'b0101;
   localparam logic [3:0] ALU_NOT  = 4'b0110;
   localparam logic [3:0] ALU_NEG  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;
   localparam logic [3:0] ALU_SLTU = 4'b1100;
   localparam logic [3:0] ALU_PASSA = 4'b1101;
   localparam logic [3:0] ALU_PASSB = 4'b1110;
   localparam logic [3:0] ALU_NAND = 4'b1111;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_mode_e;

endpackage

`default_nettype wire

// File: rtl/alu_shifter.sv
// alu_shifter: five-stage logarithmic barrel shifter (SLL / SRL / SRA), 5-bit amount.
// Rev 1.0
`default_nettype none

module alu_shifter
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] value,
   input  logic [4:0]        amount,
   input  shift_mode_e       mode,
   output logic [DATA_W-1:0] result
);

   logic [DATA_W-1:0] w_stage [0:5];
   logic              w_fill;

   assign w_fill     = (mode == SH_SRA) ? value[DATA_W-1] : 1'b0;
   assign w_stage[0] = value;

   // Stage i shifts by 2**i when amount[i] is set.
   for (genvar i = 0; i < 5; i++) begin : g_stage
      localparam int SH = 1 << i;
      logic [DATA_W-1:0] w_left;
      logic [DATA_W-1:0] w_right;

      assign w_left       = {w_stage[i][DATA_W-1-SH:0], {SH{1'b0}}};
      assign w_right      = {{SH{w_fill}}, w_stage[i][DATA_W-1:SH]};
      assign w_stage[i+1] = amount[i] ? ((mode == SH_SLL) ? w_left : w_right)
                                      : w_stage[i];
   end

   assign result = w_stage[5];

endmodule

`default_nettype wire

// File: rtl/alu.sv
// alu: registered 32-bit ALU with zero/sign flags; one-cycle latency, async active-high reset.
// Rev 1.0
`default_nettype none

module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [3:0]        funct,
   output logic [DATA_W-1:0] S,
   output logic              flagZ,
   output logic              flagS
);

   logic [DATA_W:0]   w_sub;
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_neg;
   logic              w_slt;
   logic              w_sltu;
   logic [DATA_W-1:0] w_shift;
   shift_mode_e       w_shift_mode;
   logic [DATA_W-1:0] w_result;

   // One A - B path feeds SUB, SLT and SLTU; bit 32 is the unsigned borrow.
   assign w_sub  = {1'b0, A} - {1'b0, B};
   assign w_sum  = A + B;
   assign w_neg  = '0 - B;
   assign w_sltu = w_sub[DATA_W];
   assign w_slt  = (A[DATA_W-1] != B[DATA_W-1]) ? A[DATA_W-1] : w_sub[DATA_W-1];

   always_comb begin
      w_shift_mode = SH_SRA;
      if (funct == ALU_SLL)
         w_shift_mode = SH_SLL;
      else if (funct == ALU_SRL)
         w_shift_mode = SH_SRL;
   end

   alu_shifter u_shifter (
      .value  (A),
      .amount (B[4:0]),
      .mode   (w_shift_mode),
      .result (w_shift)
   );

   always_comb begin
      w_result = '0;
      case (funct)
         ALU_ADD:   w_result = w_sum;
         ALU_SUB:   w_result = w_sub[DATA_W-1:0];
         ALU_AND:   w_result = A & B;
         ALU_OR:    w_result = A | B;
         ALU_XOR:   w_result = A ^ B;
         ALU_NOR:   w_result = ~(A | B);
         ALU_NOT:   w_result = ~A;
         ALU_NEG:   w_result = w_neg;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:   w_result = w_shift;
         ALU_SLT:   w_result = {{(DATA_W-1){1'b0}}, w_slt};
         ALU_SLTU:  w_result = {{(DATA_W-1){1'b0}}, w_sltu};
         ALU_PASSA: w_result = A;
         ALU_PASSB: w_result = B;
         ALU_NAND:  w_result = ~(A & B);
         default:   w_result = '0;
      endcase
   end

   // Flags come from the value being captured, never from the old S.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         S     <= '0;
         flagZ <= 1'b1;
         flagS <= 1'b0;
      end else begin
         S     <= w_result;
         flagZ <= (w_result == '0);
         flagS <= w_result[DATA_W-1];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// tb_alu: random and directed stimulus checked every cycle against a behavioural ALU model.
// Rev 1.0
`default_nettype none

module tb_alu;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  funct;
   logic [31:0] S;
   logic        flagZ;
   logic        flagS;

   int tests_run;
   int tests_failed;

   logic [31:0] exp_s;

   alu dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .funct (funct),
      .S     (S),
      .flagZ (flagZ),
      .flagS (flagS)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
      int unsigned sh;
      sh = int'(b % 32);
      case (f)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~(a | b);
         4'd6:    return ~a;
         4'd7:    return 32'd0 - b;
         4'd8:    return a << sh;
         4'd9:    return a >> sh;
         4'd10:   return $unsigned($signed(a) >>> sh);
         4'd11:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12:   return (a < b) ? 32'd1 : 32'd0;
         4'd13:   return a;
         4'd14:   return b;
         default: return ~(a & b);
      endcase
   endfunction

   // Reference register: what S must hold after each edge (or reset).
   always @(posedge clk or posedge rst) begin
      if (rst)
         exp_s <= 32'd0;
      else
         exp_s <= ref_alu(A, B, funct);
   end

   always @(negedge clk) begin
      tests_run++;
      if (S !== exp_s || flagZ !== (exp_s == 32'd0) || flagS !== exp_s[31]) begin
         tests_failed++;
         $display("FAIL cycle_check t=%0t funct=%0d: got S=%08h Z=%b N=%b, want S=%08h Z=%b N=%b",
                  $time, funct, S, flagZ, flagS, exp_s, exp_s == 32'd0, exp_s[31]);
      end
   end

   task automatic check_lit(input string name, input logic [31:0] want);
      tests_run++;
      if (S !== want || flagZ !== (want == 32'd0) || flagS !== want[31]) begin
         tests_failed++;
         $display("FAIL %s: got S=%08h Z=%b N=%b, want S=%08h Z=%b N=%b",
                  name, S, flagZ, flagS, want, want == 32'd0, want[31]);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
      @(negedge clk);
      A     = a;
      B     = b;
      funct = f;
   endtask

   task automatic op_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [31:0] want);
      drive(a, b, f);
      @(posedge clk);
      #1;
      check_lit(name, want);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst   = 1'b1;
      A     = 32'h1234_5678;
      B     = 32'h9ABC_DEF0;
      funct = ALU_ADD;
      #1;
      check_lit("reset_state", 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      op_lit("add_5_7",      32'd5,          32'd7,          ALU_ADD,  32'd12);
      op_lit("add_wrap",     32'hFFFF_FFFF,  32'd1,          ALU_ADD,  32'd0);
      op_lit("sub_neg",      32'd3,          32'd5,          ALU_SUB,  32'hFFFF_FFFE);
      op_lit("neg_1",        32'd0,          32'd1,          ALU_NEG,  32'hFFFF_FFFF);
      op_lit("and",          32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_AND,  32'h00F0_00F0);
      op_lit("or",           32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_OR,   32'hFFF0_FFF0);
      op_lit("xor",          32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_XOR,  32'hFF00_FF00);
      op_lit("nor",          32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_NOR,  32'h000F_000F);
      op_lit("nand",         32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_NAND, 32'hFF0F_FF0F);
      op_lit("not",          32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_NOT,  32'h0F0F_0F0F);
      op_lit("sll_1",        32'h8000_0001,  32'h0000_0021,  ALU_SLL,  32'h0000_0002);
      op_lit("srl_1",        32'h8000_0001,  32'h0000_0021,  ALU_SRL,  32'h4000_0000);
      op_lit("sra_1",        32'h8000_0001,  32'h0000_0021,  ALU_SRA,  32'hC000_0000);
      op_lit("sll_0",        32'h8000_0001,  32'h0000_0000,  ALU_SLL,  32'h8000_0001);
      op_lit("srl_0",        32'h8000_0001,  32'h0000_0000,  ALU_SRL,  32'h8000_0001);
      op_lit("sra_0",        32'h8000_0001,  32'h0000_0000,  ALU_SRA,  32'h8000_0001);
      op_lit("sra_31",       32'h8000_0000,  32'h0000_001F,  ALU_SRA,  32'hFFFF_FFFF);
      op_lit("slt_signed",   32'hFFFF_FFFF,  32'd1,          ALU_SLT,  32'd1);
      op_lit("sltu_same",    32'hFFFF_FFFF,  32'd1,          ALU_SLTU, 32'd0);
      op_lit("slt_equal",    32'd7,          32'd7,          ALU_SLT,  32'd0);
      op_lit("slt_ovf",      32'h7FFF_FFFF,  32'h8000_0000,  ALU_SLT,  32'd0);
      op_lit("passa",        32'hDEAD_BEEF,  32'h0BAD_F00D,  ALU_PASSA, 32'hDEAD_BEEF);
      op_lit("passb",        32'hDEAD_BEEF,  32'h0BAD_F00D,  ALU_PASSB, 32'h0BAD_F00D);

      // Back-to-back codes: each result must land exactly one edge later.
      for (int rep = 0; rep < 4; rep++) begin
         for (int f = 0; f < 16; f++) begin
            drive(rand_operand(), rand_operand(), 4'(f));
         end
      end

      // Mid-cycle async reset with a non-zero result pending.
      drive(32'h8000_0000, 32'd0, ALU_PASSA);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_lit("async_reset_immediate", 32'd0);
      A     = 32'h1111_1111;
      funct = ALU_PASSA;
      @(posedge clk);
      #1;
      check_lit("reset_holds_over_edge", 32'd0);
      @(negedge clk);
      rst = 1'b0;
      op_lit("first_after_reset", 32'h0000_0040, 32'h0000_0002, ALU_SRL, 32'h0000_0010);

      for (int n = 0; n < 600; n++) begin
         drive(rand_operand(), rand_operand(), 4'($urandom_range(0, 15)));
      end

      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
